// File: rtl/tt_arb_pkg.sv
// ---------------------------------------------------------------------------
// tt_arb_pkg : shared types and constants for times_table_arbiter
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } tt_arb_state_t;

  localparam int CLIENT0 = 0;
  localparam int CLIENT1 = 1;
  localparam int TT_W    = 3;

endpackage

`default_nettype wire

// File: rtl/tt_arb_rr.sv
// ---------------------------------------------------------------------------
// tt_arb_rr : 2-way round-robin picker with a registered priority pointer
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tt_arb_rr
  import tt_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr = 0 favours client 0 under contention, 1 favours client 1
  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After a grant the pointer favours whichever client did not win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[CLIENT0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/times_table_arbiter.sv
// ---------------------------------------------------------------------------
// times_table_arbiter : shares one times-table lookup unit between two clients
// Optional served0/served1 counters when TT_ARB_STATS_EN is defined.
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module times_table_arbiter
  import tt_arb_pkg::*;
#(
  parameter int W   = TT_W,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic [1:0]     done,
  output logic [2*W-1:0] result,
  output logic           busy,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           mul_read,
`ifdef TT_ARB_STATS_EN
  output logic [7:0]     served0,
  output logic [7:0]     served1,
`endif
  input  logic [2*W-1:0] mul_result
);

  tt_arb_state_t state;
  tt_arb_state_t next_state;
  logic [2:0]    wait_cnt;
  logic          winner;
  logic [1:0]    grant;
  logic          advance;

  assign advance  = (state == IDLE) && (|req);
  assign busy     = (state != IDLE);
  assign mul_read = (state == ISSUE);

  tt_arb_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (wait_cnt == 3'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are frozen at grant; the counter covers the lookup latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 3'd0;
      winner   <= 1'b0;
      done     <= 2'b00;
      result   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
`ifdef TT_ARB_STATS_EN
      served0  <= 8'd0;
      served1  <= 8'd0;
`endif
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (advance) begin
            winner <= grant[CLIENT1];
            mul_a  <= grant[CLIENT1] ? a1 : a0;
            mul_b  <= grant[CLIENT1] ? b1 : b0;
          end
        end
        ISSUE: wait_cnt <= 3'(LAT - 1);
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            result <= mul_result;
            done   <= winner ? 2'b10 : 2'b01;
`ifdef TT_ARB_STATS_EN
            if (winner) served1 <= served1 + 8'd1;
            else        served0 <= served0 + 8'd1;
`endif
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_times_table_arbiter.sv
// ---------------------------------------------------------------------------
// tb_times_table_arbiter : two arbiters (LAT=1 and LAT=3) against a reference model
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_times_table_arbiter;

  localparam int W    = 3;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n      [2];
  logic [1:0]     req        [2];
  logic [W-1:0]   a0         [2];
  logic [W-1:0]   b0         [2];
  logic [W-1:0]   a1         [2];
  logic [W-1:0]   b1         [2];
  logic [1:0]     done       [2];
  logic [2*W-1:0] result     [2];
  logic           busy       [2];
  logic [W-1:0]   mul_a      [2];
  logic [W-1:0]   mul_b      [2];
  logic           mul_read   [2];
  logic [2*W-1:0] mul_result [2];
`ifdef TT_ARB_STATS_EN
  logic [7:0]     served0    [2];
  logic [7:0]     served1    [2];
`endif

  times_table_arbiter #(.W(W), .LAT(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]),
    .a0(a0[0]), .b0(b0[0]), .a1(a1[0]), .b1(b1[0]),
    .done(done[0]), .result(result[0]), .busy(busy[0]),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_read(mul_read[0]),
`ifdef TT_ARB_STATS_EN
    .served0(served0[0]), .served1(served1[0]),
`endif
    .mul_result(mul_result[0])
  );

  times_table_arbiter #(.W(W), .LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]),
    .a0(a0[1]), .b0(b0[1]), .a1(a1[1]), .b1(b1[1]),
    .done(done[1]), .result(result[1]), .busy(busy[1]),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_read(mul_read[1]),
`ifdef TT_ARB_STATS_EN
    .served0(served0[1]), .served1(served1[1]),
`endif
    .mul_result(mul_result[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Lookup unit: product valid LAT edges after read; junk at any other time
  logic [2*W-1:0] mpipe [2][8];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i > 0; i--) mpipe[k][i] <= mpipe[k][i-1];
      mpipe[k][0] <= mul_read[k] ? ({3'b000, mul_a[k]} * {3'b000, mul_b[k]})
                                 : 6'($urandom);
    end
  end
  assign mul_result[0] = mpipe[0][LAT0-1];
  assign mul_result[1] = mpipe[1][LAT1-1];

  // Transaction-level model: grant edge number, winner, and timing from it
  int             cyc = 0;
  int             gnt [2] = '{-100, -100};
  int             win [2];
  logic           ptr [2];
  logic [W-1:0]   la  [2];
  logic [W-1:0]   lb  [2];
  logic [2*W-1:0] prod[2];
  logic [2*W-1:0] res [2];
  int             srv [2][2];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        gnt[k] = -100; win[k] = 0; ptr[k] = 1'b0;
        la[k] = '0; lb[k] = '0; res[k] = '0; prod[k] = '0;
        srv[k][0] = 0; srv[k][1] = 0;
      end else begin
        if (cyc == gnt[k] + lat(k) + 1) begin
          res[k] = prod[k];
          srv[k][win[k]] = (srv[k][win[k]] + 1) % 256;
        end
        if (cyc >= gnt[k] + lat(k) + 3 && req[k] != 2'b00) begin
          win[k]  = (req[k] == 2'b11) ? int'(ptr[k]) : int'(req[k][1]);
          ptr[k]  = (win[k] == 0);
          la[k]   = (win[k] == 1) ? a1[k] : a0[k];
          lb[k]   = (win[k] == 1) ? b1[k] : b0[k];
          prod[k] = {3'b000, la[k]} * {3'b000, lb[k]};
          gnt[k]  = cyc;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int  d    = gnt[k] + lat(k) + 1;
      logic act = rst_n[k] && cyc >= gnt[k] && cyc <= d;
      check($sformatf("busy%0d", k),     32'(busy[k]),     32'(act));
      check($sformatf("mul_read%0d", k), 32'(mul_read[k]), 32'(rst_n[k] && cyc == gnt[k]));
      check($sformatf("done%0d", k),     32'(done[k]),
            (rst_n[k] && cyc == d) ? ((win[k] == 1) ? 32'd2 : 32'd1) : 32'd0);
      check($sformatf("result%0d", k),   32'(result[k]),   32'(res[k]));
      check($sformatf("mul_a%0d", k),    32'(mul_a[k]),    32'(la[k]));
      check($sformatf("mul_b%0d", k),    32'(mul_b[k]),    32'(lb[k]));
`ifdef TT_ARB_STATS_EN
      check($sformatf("served0_%0d", k), 32'(served0[k]),  32'(srv[k][0]));
      check($sformatf("served1_%0d", k), 32'(served1[k]),  32'(srv[k][1]));
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_done(input int k, input int maxc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (done[k] == 2'b00 && n < maxc);
    check($sformatf("done_seen%0d", k), 32'(done[k] != 2'b00), 32'd1);
  endtask

  task automatic wait_read(input int k, input int maxc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!mul_read[k] && n < maxc);
    check($sformatf("read_seen%0d", k), 32'(mul_read[k]), 32'd1);
  endtask

  task automatic rand_ops(input int k, input int c);
    if (c == 0) begin a0[k] = 3'($urandom); b0[k] = 3'($urandom); end
    else        begin a1[k] = 3'($urandom); b1[k] = 3'($urandom); end
  endtask

  task automatic rand_drive(input int k);
    if (!rst_n[k]) rst_n[k] = 1'b1;
    else if ($urandom_range(0, 399) == 0) rst_n[k] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      int  d        = gnt[k] + lat(k) + 1;
      logic inflight = (win[k] == c) && cyc >= gnt[k] && cyc <= d;
      if (inflight && cyc < d) begin
        int r = $urandom_range(0, 7);
        if (r == 0)     req[k][c] = 1'b0;
        else if (r < 3) rand_ops(k, c);
      end else if (inflight) begin
        if ($urandom_range(0, 1) == 0) req[k][c] = 1'b0;
        else begin req[k][c] = 1'b1; rand_ops(k, c); end
      end else if (!req[k][c] && $urandom_range(0, 2) == 0) begin
        rand_ops(k, c);
        req[k][c] = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req[k] = 2'b00;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    repeat (3) tick();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Single request on each instance; ticks counted from the negedge raising req
    req[0] = 2'b01; a0[0] = 3'd3; b0[0] = 3'd5;
    req[1] = 2'b01; a0[1] = 3'd7; b0[1] = 3'd7;
    t0 = -1; t1 = -1;
    for (int n = 1; n <= 20 && (t0 < 0 || t1 < 0); n++) begin
      tick();
      if (t0 < 0 && done[0] != 2'b00) begin
        t0 = n; check("single_res0", 32'(result[0]), 32'd15); req[0] = 2'b00;
      end
      if (t1 < 0 && done[1] != 2'b00) begin
        t1 = n; check("single_res1", 32'(result[1]), 32'd49); req[1] = 2'b00;
      end
    end
    check("single_lat0", 32'(t0), 32'(LAT0 + 2));
    check("single_lat1", 32'(t1), 32'(LAT1 + 2));

    // Contention from a fresh pointer: strict alternation starting at client 0
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    req[0] = 2'b11; a0[0] = 3'd3; b0[0] = 3'd2; a1[0] = 3'd7; b1[0] = 3'd7;
    for (int t = 0; t < 6; t++) begin
      wait_done(0, 20);
      check("cont_done", 32'(done[0]),   (t % 2 == 1) ? 32'd2  : 32'd1);
      check("cont_res",  32'(result[0]), (t % 2 == 1) ? 32'd49 : 32'd6);
    end
    req[0] = 2'b00;
    tick();

    // Operand change after grant must not reach the product
    req[0] = 2'b01; a0[0] = 3'd3; b0[0] = 3'd5;
    wait_read(0, 10);
    a0[0] = 3'd6;
    wait_done(0, 20);
    check("latch_res", 32'(result[0]), 32'd15);
    req[0] = 2'b00;

    // Reset during WAIT: immediate clear, then fresh service of held req
    req[1] = 2'b01; a0[1] = 3'd6; b0[1] = 3'd7;
    wait_read(1, 10);
    tick();
    rst_n[1] = 1'b0;
    #1;
    check("rst_done",  32'(done[1]),     32'd0);
    check("rst_busy",  32'(busy[1]),     32'd0);
    check("rst_res",   32'(result[1]),   32'd0);
    check("rst_mula",  32'(mul_a[1]),    32'd0);
    check("rst_mulb",  32'(mul_b[1]),    32'd0);
    check("rst_read",  32'(mul_read[1]), 32'd0);
    repeat (2) tick();
    rst_n[1] = 1'b1;
    wait_done(1, 20);
    check("reserve_done", 32'(done[1]),   32'd1);
    check("reserve_res",  32'(result[1]), 32'd42);
    req[1] = 2'b00;

    // 256 back-to-back client-0 transactions
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    req[0] = 2'b01; a0[0] = 3'd5; b0[0] = 3'd6;
    repeat (256) wait_done(0, 20);
    check("wrap_res", 32'(result[0]), 32'd30);
    req[0] = 2'b00;
    tick();
`ifdef TT_ARB_STATS_EN
    check("wrap_served0", 32'(served0[0]), 32'd0);
    check("wrap_served1", 32'(served1[0]), 32'd0);
`endif

    repeat (3000) begin
      tick();
      rand_drive(0);
      rand_drive(1);
    end
    req[0] = 2'b00; req[1] = 2'b00;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
